// File: rtl/pq_cmd_ctl.sv
// Board-level command controller for a priority queue: debounces the enq/deq/replace buttons,
// arbitrates them, and issues one legal single-cycle strobe per accepted press.
module pq_cmd_ctl #(
  parameter int KEY_W     = 8,
  parameter int VAL_W     = 8,
  parameter int DEPTH     = 8,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8,
  localparam int KV_W     = KEY_W + VAL_W,
  localparam int OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_enq,
  input  logic             btn_deq,
  input  logic             btn_rep,
  input  logic [KV_W-1:0]  kv_sw,
  input  logic             pq_full,
  input  logic             pq_empty,
  input  logic             pq_busy,
  input  logic [KV_W-1:0]  pq_kvo,
  output logic             pq_enq,
  output logic             pq_deq,
  output logic [KV_W-1:0]  pq_kvi,
  output logic [KV_W-1:0]  disp_kv,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             pending
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;
  typedef enum logic [1:0] {CMD_ENQ, CMD_DEQ, CMD_REP} cmd_t;

  logic [2:0]       btn_s;
  logic [2:0]       lvl_q;
  logic [2:0]       req_q;
  logic [DBW-1:0]   db_cnt_q [3];

  state_t           state_q;
  cmd_t             cmd_q;
  cmd_t             cmd_win_s;
  logic             req_any_s;
  logic [1:0]       n_req_s;
  logic [1:0]       drop_n_s;
  logic             illegal_s;

  logic             pq_enq_q;
  logic             pq_deq_q;
  logic [KV_W-1:0]  pq_kvi_q;
  logic [KV_W-1:0]  disp_kv_q;
  logic [OCC_W-1:0] occ_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             pending_q;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    sat_add = s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign btn_s = {btn_rep, btn_deq, btn_enq};

  // Debounce: the level flips after DB_CYCLES consecutive samples that disagree with it; a rising flip is a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q <= 3'b000;
      req_q <= 3'b000;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (btn_s[i] != lvl_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            lvl_q[i]    <= btn_s[i];
            db_cnt_q[i] <= '0;
            req_q[i]    <= btn_s[i];
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
            req_q[i]    <= 1'b0;
          end
        end else begin
          db_cnt_q[i] <= '0;
          req_q[i]    <= 1'b0;
        end
      end
    end
  end

  // Arbitration rep > deq > enq; every request that does not start a command counts as dropped.
  always_comb begin
    req_any_s = |req_q;
    n_req_s   = 2'(req_q[0]) + 2'(req_q[1]) + 2'(req_q[2]);
    if (req_q[2]) begin
      cmd_win_s = CMD_REP;
    end else if (req_q[1]) begin
      cmd_win_s = CMD_DEQ;
    end else begin
      cmd_win_s = CMD_ENQ;
    end
    if ((state_q == S_IDLE) && req_any_s) begin
      drop_n_s = n_req_s - 2'd1;
    end else begin
      drop_n_s = n_req_s;
    end
    illegal_s = ((cmd_q == CMD_ENQ) && pq_full) || ((cmd_q != CMD_ENQ) && pq_empty);
  end

  // Command FSM; strobes, kv and occupancy are registered on the WAIT->ISSUE transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= CMD_ENQ;
      pq_enq_q   <= 1'b0;
      pq_deq_q   <= 1'b0;
      pq_kvi_q   <= '0;
      disp_kv_q  <= '0;
      occ_q      <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      pq_enq_q   <= 1'b0;
      pq_deq_q   <= 1'b0;
      pq_kvi_q   <= '0;
      drop_cnt_q <= sat_add(drop_cnt_q, drop_n_s);
      case (state_q)
        S_IDLE: begin
          if (req_any_s) begin
            cmd_q     <= cmd_win_s;
            state_q   <= S_WAIT;
            pending_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!pq_busy) begin
            if (illegal_s) begin
              err_cnt_q <= sat_add(err_cnt_q, 2'd1);
              state_q   <= S_IDLE;
              pending_q <= 1'b0;
            end else begin
              state_q  <= S_ISSUE;
              pq_kvi_q <= kv_sw;
              case (cmd_q)
                CMD_ENQ: begin
                  pq_enq_q <= 1'b1;
                  if (occ_q < OCC_W'(DEPTH)) occ_q <= occ_q + OCC_W'(1);
                end
                CMD_DEQ: begin
                  pq_deq_q  <= 1'b1;
                  disp_kv_q <= pq_kvo;
                  if (occ_q != '0) occ_q <= occ_q - OCC_W'(1);
                end
                default: begin
                  pq_enq_q  <= 1'b1;
                  pq_deq_q  <= 1'b1;
                  disp_kv_q <= pq_kvo;
                end
              endcase
            end
          end
        end
        S_ISSUE: begin
          state_q   <= S_IDLE;
          pending_q <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign pq_enq    = pq_enq_q;
  assign pq_deq    = pq_deq_q;
  assign pq_kvi    = pq_kvi_q;
  assign disp_kv   = disp_kv_q;
  assign occupancy = occ_q;
  assign err_cnt   = err_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign pending   = pending_q;

endmodule
